// File: rtl/riscv_load_tag_queue_if.sv
// Load issue / response / destination-tag write bundle for riscv_load_tag_queue.
// The master side issues loads and returns responses; the slave side is the queue.
interface riscv_load_tag_queue_if #(
   parameter int TAG_WIDTH      = 1,
   parameter int REG_ADDR_WIDTH = 5
);
   logic                      req_valid_i;
   logic                      req_ready_o;
   logic [TAG_WIDTH-1:0]      req_rs1_tag_i;
   logic [REG_ADDR_WIDTH-1:0] req_rd_addr_i;
   logic                      rsp_valid_i;
   logic [TAG_WIDTH-1:0]      rsp_mem_tag_i;
   logic                      rsp_we_i;
   logic                      tag_we_o;
   logic [REG_ADDR_WIDTH-1:0] tag_waddr_o;
   logic [TAG_WIDTH-1:0]      tag_wdata_o;

   modport master (
      output req_valid_i, req_rs1_tag_i, req_rd_addr_i,
      output rsp_valid_i, rsp_mem_tag_i, rsp_we_i,
      input  req_ready_o, tag_we_o, tag_waddr_o, tag_wdata_o
   );

   modport slave (
      input  req_valid_i, req_rs1_tag_i, req_rd_addr_i,
      input  rsp_valid_i, rsp_mem_tag_i, rsp_we_i,
      output req_ready_o, tag_we_o, tag_waddr_o, tag_wdata_o
   );
endinterface

// File: rtl/riscv_load_tag_queue.sv
// In-order queue of outstanding load tag contexts; emits a registered destination-tag write per response.
// Optional macro LOAD_TAG_CHECK_EN adds tcr_chk_i / load_tag_exc_o address-tag checking.
module riscv_load_tag_queue #(
   parameter int TAG_WIDTH      = 1,
   parameter int DEPTH          = 2,
   parameter int REG_ADDR_WIDTH = 5
) (
   input  logic                          clk,
   input  logic                          rst_n,
   riscv_load_tag_queue_if.slave         bus,
   input  logic [31:0]                   tpr_i,
   input  logic                          flush_i,
`ifdef LOAD_TAG_CHECK_EN
   input  logic                          tcr_chk_i,
   output logic                          load_tag_exc_o,
`endif
   output logic [$clog2(DEPTH+1)-1:0]    count_o,
   output logic                          rsp_err_o
);

   localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int CNT_W = $clog2(DEPTH+1);

   // TPR field positions and propagation modes, mirroring riscv_defines
   localparam int LOADSTORE_HIGH           = 19;
   localparam int LOADSTORE_LOW            = 18;
   localparam int LOADSTORE_EN_SOURCE_ADDR = 17;
   localparam int LOADSTORE_EN_SOURCE      = 16;

   localparam logic [1:0] ALU_MODE_OLD   = 2'b00;
   localparam logic [1:0] ALU_MODE_AND   = 2'b01;
   localparam logic [1:0] ALU_MODE_OR    = 2'b10;
   localparam logic [1:0] ALU_MODE_CLEAR = 2'b11;

   logic [TAG_WIDTH-1:0]      rs1_tag_q [DEPTH];
   logic [REG_ADDR_WIDTH-1:0] rd_addr_q [DEPTH];
   logic [1:0]                mode_q    [DEPTH];
   logic [DEPTH-1:0]          en_a_q;
   logic [DEPTH-1:0]          en_b_q;

   logic [PTR_W-1:0]          wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0]          rd_ptr_q, rd_ptr_d;
   logic [CNT_W-1:0]          count_q, count_d;
   logic                      tag_we_q, tag_we_d;
   logic [REG_ADDR_WIDTH-1:0] tag_waddr_q, tag_waddr_d;
   logic [TAG_WIDTH-1:0]      tag_wdata_q, tag_wdata_d;
   logic                      rsp_err_q, rsp_err_d;

   logic                      full;
   logic                      empty;
   logic                      push;
   logic                      pop;
   logic [TAG_WIDTH-1:0]      src_a;
   logic [TAG_WIDTH-1:0]      src_b;
   logic [TAG_WIDTH-1:0]      result;
   logic                      mode_writes;

   assign full  = (count_q == CNT_W'(DEPTH));
   assign empty = (count_q == '0);

   // Flush wins over both sides; a response on an empty queue never sees a same-cycle push
   assign push = bus.req_valid_i && !full  && !flush_i;
   assign pop  = bus.rsp_valid_i && !empty && !flush_i;

   always_comb begin
      src_a       = rs1_tag_q[rd_ptr_q] & {TAG_WIDTH{en_a_q[rd_ptr_q]}};
      src_b       = bus.rsp_mem_tag_i   & {TAG_WIDTH{en_b_q[rd_ptr_q]}};
      result      = '0;
      mode_writes = 1'b0;
      case (mode_q[rd_ptr_q])
         ALU_MODE_AND:   begin result = src_a & src_b; mode_writes = 1'b1; end
         ALU_MODE_OR:    begin result = src_a | src_b; mode_writes = 1'b1; end
         ALU_MODE_CLEAR: begin result = '0;            mode_writes = 1'b1; end
         default:        begin result = '0;            mode_writes = 1'b0; end
      endcase
   end

   always_comb begin
      wr_ptr_d    = wr_ptr_q;
      rd_ptr_d    = rd_ptr_q;
      count_d     = count_q;
      tag_waddr_d = tag_waddr_q;
      tag_wdata_d = tag_wdata_q;
      tag_we_d    = pop && bus.rsp_we_i && mode_writes;
      rsp_err_d   = bus.rsp_valid_i && empty && !flush_i;
      if (flush_i) begin
         wr_ptr_d = '0;
         rd_ptr_d = '0;
         count_d  = '0;
      end else begin
         if (push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
         if (pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
         if (push && !pop)      count_d = count_q + CNT_W'(1);
         else if (pop && !push) count_d = count_q - CNT_W'(1);
      end
      if (pop) begin
         tag_waddr_d = rd_addr_q[rd_ptr_q];
         tag_wdata_d = result;
      end
   end

   // Entry payload needs no reset: it is only read behind a non-zero count
   always_ff @(posedge clk) begin
      if (push) begin
         rs1_tag_q[wr_ptr_q] <= bus.req_rs1_tag_i;
         rd_addr_q[wr_ptr_q] <= bus.req_rd_addr_i;
         mode_q[wr_ptr_q]    <= tpr_i[LOADSTORE_HIGH:LOADSTORE_LOW];
         en_a_q[wr_ptr_q]    <= tpr_i[LOADSTORE_EN_SOURCE_ADDR];
         en_b_q[wr_ptr_q]    <= tpr_i[LOADSTORE_EN_SOURCE];
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr_q    <= '0;
         rd_ptr_q    <= '0;
         count_q     <= '0;
         tag_we_q    <= 1'b0;
         tag_waddr_q <= '0;
         tag_wdata_q <= '0;
         rsp_err_q   <= 1'b0;
      end else begin
         wr_ptr_q    <= wr_ptr_d;
         rd_ptr_q    <= rd_ptr_d;
         count_q     <= count_d;
         tag_we_q    <= tag_we_d;
         tag_waddr_q <= tag_waddr_d;
         tag_wdata_q <= tag_wdata_d;
         rsp_err_q   <= rsp_err_d;
      end
   end

`ifdef LOAD_TAG_CHECK_EN
   logic load_tag_exc_q, load_tag_exc_d;

   assign load_tag_exc_d = pop && tcr_chk_i && (rs1_tag_q[rd_ptr_q] != '0);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) load_tag_exc_q <= 1'b0;
      else        load_tag_exc_q <= load_tag_exc_d;
   end

   assign load_tag_exc_o = load_tag_exc_q;
`endif

   assign bus.req_ready_o = !full;
   assign bus.tag_we_o    = tag_we_q;
   assign bus.tag_waddr_o = tag_waddr_q;
   assign bus.tag_wdata_o = tag_wdata_q;
   assign count_o         = count_q;
   assign rsp_err_o       = rsp_err_q;

endmodule

// File: tb/tb_riscv_load_tag_queue.sv
// Directed, table-driven bench for riscv_load_tag_queue (TAG_WIDTH=4, DEPTH=2).
// Each vector is one clock cycle; outputs are compared 1 time unit after the rising edge.
module tb_riscv_load_tag_queue;

   localparam int TW    = 4;
   localparam int DEPTH = 2;
   localparam int AW    = 5;
   localparam int CW    = $clog2(DEPTH+1);

   localparam logic [1:0] M_OLD = 2'b00;
   localparam logic [1:0] M_AND = 2'b01;
   localparam logic [1:0] M_OR  = 2'b10;
   localparam logic [1:0] M_CLR = 2'b11;

   typedef struct {
      logic          req_valid;
      logic [TW-1:0] rs1;
      logic [AW-1:0] rd;
      logic [1:0]    mode;
      logic          en_a;
      logic          en_b;
      logic          rsp_valid;
      logic [TW-1:0] mem;
      logic          rsp_we;
      logic          flush;
      logic          e_ready;
      logic [CW-1:0] e_count;
      logic          e_we;
      logic [AW-1:0] e_waddr;
      logic [TW-1:0] e_wdata;
      logic          e_err;
   } vec_t;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic [31:0]   tpr_i;
   logic          flush_i;
   logic [CW-1:0] count_o;
   logic          rsp_err_o;
`ifdef LOAD_TAG_CHECK_EN
   logic          tcr_chk_i = 1'b0;
   logic          load_tag_exc_o;
`endif

   int checks   = 0;
   int failures = 0;
   vec_t vecs[$];

   riscv_load_tag_queue_if #(.TAG_WIDTH(TW), .REG_ADDR_WIDTH(AW)) bus ();

   riscv_load_tag_queue #(.TAG_WIDTH(TW), .DEPTH(DEPTH), .REG_ADDR_WIDTH(AW)) dut (
      .clk            (clk),
      .rst_n          (rst_n),
      .bus            (bus),
      .tpr_i          (tpr_i),
      .flush_i        (flush_i),
`ifdef LOAD_TAG_CHECK_EN
      .tcr_chk_i      (tcr_chk_i),
      .load_tag_exc_o (load_tag_exc_o),
`endif
      .count_o        (count_o),
      .rsp_err_o      (rsp_err_o)
   );

   always #5 clk = ~clk;

   function automatic logic [31:0] tpr_word(input logic [1:0] mode, input logic en_a, input logic en_b);
      logic [31:0] w;
      w        = '0;
      w[19:18] = mode;
      w[17]    = en_a;
      w[16]    = en_b;
      return w;
   endfunction

   function automatic vec_t mk(
      input logic rv, input logic [TW-1:0] rs1, input logic [AW-1:0] rd, input logic [1:0] mode,
      input logic ea, input logic eb, input logic sv, input logic [TW-1:0] mem, input logic we,
      input logic fl, input logic e_ready, input logic [CW-1:0] e_count, input logic e_we,
      input logic [AW-1:0] e_waddr, input logic [TW-1:0] e_wdata, input logic e_err);
      vec_t v;
      v.req_valid = rv;  v.rs1 = rs1;   v.rd = rd;       v.mode = mode;
      v.en_a = ea;       v.en_b = eb;   v.rsp_valid = sv; v.mem = mem;
      v.rsp_we = we;     v.flush = fl;  v.e_ready = e_ready; v.e_count = e_count;
      v.e_we = e_we;     v.e_waddr = e_waddr; v.e_wdata = e_wdata; v.e_err = e_err;
      return v;
   endfunction

   task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic driveIdle();
      bus.req_valid_i   = 1'b0;
      bus.req_rs1_tag_i = '0;
      bus.req_rd_addr_i = '0;
      bus.rsp_valid_i   = 1'b0;
      bus.rsp_mem_tag_i = '0;
      bus.rsp_we_i      = 1'b0;
      flush_i           = 1'b0;
      tpr_i             = '0;
   endtask

   task automatic applyStimulus(input vec_t v, input int idx);
      @(negedge clk);
      bus.req_valid_i   = v.req_valid;
      bus.req_rs1_tag_i = v.rs1;
      bus.req_rd_addr_i = v.rd;
      tpr_i             = tpr_word(v.mode, v.en_a, v.en_b);
      bus.rsp_valid_i   = v.rsp_valid;
      bus.rsp_mem_tag_i = v.mem;
      bus.rsp_we_i      = v.rsp_we;
      flush_i           = v.flush;
      @(posedge clk);
      #1;
      checkOutput($sformatf("v%0d.ready", idx), 32'(bus.req_ready_o), 32'(v.e_ready));
      checkOutput($sformatf("v%0d.count", idx), 32'(count_o),         32'(v.e_count));
      checkOutput($sformatf("v%0d.we",    idx), 32'(bus.tag_we_o),    32'(v.e_we));
      checkOutput($sformatf("v%0d.err",   idx), 32'(rsp_err_o),       32'(v.e_err));
      if (v.e_we) begin
         checkOutput($sformatf("v%0d.waddr", idx), 32'(bus.tag_waddr_o), 32'(v.e_waddr));
         checkOutput($sformatf("v%0d.wdata", idx), 32'(bus.tag_wdata_o), 32'(v.e_wdata));
      end
   endtask

   initial begin
      // rv rs1 rd mode ea eb | sv mem we fl || ready count we waddr wdata err
      vecs.push_back(mk(1, 4'h1,  5, M_OR,  1, 1, 0, 4'h0, 0, 0, 1, 1, 0,  0, 4'h0, 0));
      vecs.push_back(mk(0, 4'h0,  0, M_OR,  1, 1, 1, 4'h0, 1, 0, 1, 0, 1,  5, 4'h1, 0));
      vecs.push_back(mk(0, 4'h0,  0, M_OR,  1, 1, 0, 4'h0, 0, 0, 1, 0, 0,  0, 4'h0, 0));
      vecs.push_back(mk(1, 4'hC,  6, M_AND, 1, 1, 0, 4'h0, 0, 0, 1, 1, 0,  0, 4'h0, 0));
      vecs.push_back(mk(0, 4'h0,  0, M_AND, 1, 1, 1, 4'hA, 1, 0, 1, 0, 1,  6, 4'h8, 0));
      vecs.push_back(mk(1, 4'hC,  7, M_AND, 1, 0, 0, 4'h0, 0, 0, 1, 1, 0,  0, 4'h0, 0));
      vecs.push_back(mk(0, 4'h0,  0, M_AND, 1, 0, 1, 4'hA, 1, 0, 1, 0, 1,  7, 4'h0, 0));
      vecs.push_back(mk(1, 4'h1,  8, M_CLR, 1, 1, 0, 4'h0, 0, 0, 1, 1, 0,  0, 4'h0, 0));
      vecs.push_back(mk(0, 4'h0,  0, M_OR,  1, 1, 0, 4'h0, 0, 0, 1, 1, 0,  0, 4'h0, 0));
      vecs.push_back(mk(0, 4'h0,  0, M_OR,  1, 1, 1, 4'h1, 1, 0, 1, 0, 1,  8, 4'h0, 0));
      vecs.push_back(mk(1, 4'hF,  9, M_OLD, 1, 1, 0, 4'h0, 0, 0, 1, 1, 0,  0, 4'h0, 0));
      vecs.push_back(mk(0, 4'h0,  0, M_OR,  1, 1, 1, 4'hF, 1, 0, 1, 0, 0,  0, 4'h0, 0));
      vecs.push_back(mk(1, 4'h3, 10, M_OR,  1, 1, 0, 4'h0, 0, 0, 1, 1, 0,  0, 4'h0, 0));
      vecs.push_back(mk(0, 4'h0,  0, M_OR,  1, 1, 1, 4'hF, 0, 0, 1, 0, 0,  0, 4'h0, 0));
      vecs.push_back(mk(0, 4'h0,  0, M_OR,  1, 1, 1, 4'h0, 1, 0, 1, 0, 0,  0, 4'h0, 1));
      vecs.push_back(mk(0, 4'h0,  0, M_OR,  1, 1, 0, 4'h0, 0, 0, 1, 0, 0,  0, 4'h0, 0));
      vecs.push_back(mk(1, 4'h1,  1, M_OR,  1, 1, 0, 4'h0, 0, 0, 1, 1, 0,  0, 4'h0, 0));
      vecs.push_back(mk(1, 4'h2,  2, M_OR,  1, 1, 0, 4'h0, 0, 0, 0, 2, 0,  0, 4'h0, 0));
      vecs.push_back(mk(1, 4'h4,  3, M_OR,  1, 1, 0, 4'h0, 0, 0, 0, 2, 0,  0, 4'h0, 0));
      vecs.push_back(mk(1, 4'h4,  3, M_OR,  1, 1, 1, 4'h0, 1, 0, 1, 1, 1,  1, 4'h1, 0));
      vecs.push_back(mk(1, 4'h4,  3, M_OR,  1, 1, 1, 4'h0, 1, 0, 1, 1, 1,  2, 4'h2, 0));
      vecs.push_back(mk(1, 4'h8,  4, M_OR,  1, 1, 0, 4'h0, 0, 0, 0, 2, 0,  0, 4'h0, 0));
      vecs.push_back(mk(0, 4'h0,  0, M_OR,  1, 1, 1, 4'h0, 1, 0, 1, 1, 1,  3, 4'h4, 0));
      vecs.push_back(mk(1, 4'h1,  5, M_OR,  1, 1, 1, 4'h0, 1, 0, 1, 1, 1,  4, 4'h8, 0));
      vecs.push_back(mk(1, 4'h2,  6, M_OR,  1, 1, 0, 4'h0, 0, 0, 0, 2, 0,  0, 4'h0, 0));
      vecs.push_back(mk(1, 4'h4, 12, M_OR,  1, 1, 1, 4'hF, 1, 1, 1, 0, 0,  0, 4'h0, 0));
      vecs.push_back(mk(0, 4'h0,  0, M_OR,  1, 1, 0, 4'h0, 0, 0, 1, 0, 0,  0, 4'h0, 0));
      vecs.push_back(mk(1, 4'h1, 11, M_OR,  1, 1, 1, 4'h0, 1, 0, 1, 1, 0,  0, 4'h0, 1));
      vecs.push_back(mk(0, 4'h0,  0, M_OR,  1, 1, 1, 4'h0, 1, 0, 1, 0, 1, 11, 4'h1, 0));

      driveIdle();
      rst_n = 1'b0;
      #12;
      checkOutput("reset.ready", 32'(bus.req_ready_o), 32'd1);
      checkOutput("reset.count", 32'(count_o),         32'd0);
      checkOutput("reset.we",    32'(bus.tag_we_o),    32'd0);
      checkOutput("reset.waddr", 32'(bus.tag_waddr_o), 32'd0);
      checkOutput("reset.wdata", 32'(bus.tag_wdata_o), 32'd0);
      checkOutput("reset.err",   32'(rsp_err_o),       32'd0);
      @(negedge clk);
      rst_n = 1'b1;

      for (int i = 0; i < vecs.size(); i++) applyStimulus(vecs[i], i);

      // Reset in the middle of operation: one entry queued, then async reset mid-cycle
      applyStimulus(mk(1, 4'h5, 13, M_OR, 1, 1, 0, 4'h0, 0, 0, 1, 1, 0, 0, 4'h0, 0), 100);
      applyStimulus(mk(1, 4'h3, 14, M_OR, 1, 1, 1, 4'h6, 1, 0, 1, 1, 1, 13, 4'h7, 0), 101);
      @(negedge clk);
      driveIdle();
      #2;
      rst_n = 1'b0;
      #1;
      checkOutput("midrst.count", 32'(count_o),         32'd0);
      checkOutput("midrst.ready", 32'(bus.req_ready_o), 32'd1);
      checkOutput("midrst.we",    32'(bus.tag_we_o),    32'd0);
      checkOutput("midrst.waddr", 32'(bus.tag_waddr_o), 32'd0);
      checkOutput("midrst.wdata", 32'(bus.tag_wdata_o), 32'd0);
      @(posedge clk);
      #1;
      checkOutput("midrst.hold_we", 32'(bus.tag_we_o), 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      applyStimulus(mk(0, 4'h0, 0, M_OR, 1, 1, 1, 4'h1, 1, 0, 1, 0, 0, 0, 4'h0, 1), 102);
      applyStimulus(mk(0, 4'h0, 0, M_OR, 1, 1, 0, 4'h0, 0, 0, 1, 0, 0, 0, 4'h0, 0), 103);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/riscv_load_tag_queue.md
Name: riscv_load_tag_queue

Overview:
- Parametrised successor to the single-cycle LOAD tag propagation logic.
- Decouples load issue (EX) from load writeback (WB):
  - captures rs1 address tag, rd address and a TPR snapshot per outstanding load in an in-order queue;
  - on response, combines the snapshot with the returned memory tag and emits a registered destination-tag write to the tag register file.
- Supports multi-bit tags and multiple outstanding loads.

Parameters:
- TAG_WIDTH, 1: width of every tag (rs1, memory, destination).
- DEPTH, 2: number of outstanding loads; power of two, at least 2.
- REG_ADDR_WIDTH, 5: destination register address width.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- req_valid_i  in  1  load issued this cycle.
- req_ready_o  out  1  queue can accept a request.
- req_rs1_tag_i  in  TAG_WIDTH  source-address (rs1) tag.
- req_rd_addr_i  in  REG_ADDR_WIDTH  load destination register.
- tpr_i  in  32  Tag Propagation Register; LOADSTORE_HIGH:LOADSTORE_LOW, LOADSTORE_EN_SOURCE_ADDR and LOADSTORE_EN_SOURCE from riscv_defines.
- rsp_valid_i  in  1  load data returned (pops head).
- rsp_mem_tag_i  in  TAG_WIDTH  tag of the loaded memory word.
- rsp_we_i  in  1  writeback enabled for this response.
- flush_i  in  1  discard all outstanding entries.
- tag_we_o  out  1  destination-tag write enable.
- tag_waddr_o  out  REG_ADDR_WIDTH  destination-tag write address.
- tag_wdata_o  out  TAG_WIDTH  destination tag.
- count_o  out  $clog2(DEPTH+1)  occupancy.
- rsp_err_o  out  1  one-cycle pulse: response with empty queue.

Behaviour:
- Reset (async, rst_n=0): pointers and count cleared; tag_we_o=0, tag_waddr_o=0, tag_wdata_o=0, rsp_err_o=0; req_ready_o=1 combinationally after reset.
- Reset mid-operation discards all entries immediately. No output pulse is produced for entries lost to reset.
- Entry contents: rs1_tag, rd_addr, mode (2 bits), en_a, en_b. TPR is sampled at push, so later TPR writes do not affect queued loads.
- Push when req_valid_i && req_ready_o.
- req_ready_o = (count != DEPTH). There is no same-cycle pop-to-push bypass when full.
- Pop when rsp_valid_i && count != 0. Pop uses the head entry; the response is matched in order.
- Push and pop in the same cycle: count unchanged; both pointers advance and wrap modulo DEPTH.
- Empty queue + push + rsp in the same cycle: the response sees empty (no bypass); the entry is pushed.
- rsp_valid_i with count==0 → rsp_err_o=1 the next cycle; no tag write.
- Propagation on pop:
  - a = rs1_tag & {TAG_WIDTH{en_a}}
  - b = rsp_mem_tag_i & {TAG_WIDTH{en_b}}
  - ALU_MODE_OLD → no write (tag_we_o=0);
  - ALU_MODE_AND → a & b;
  - ALU_MODE_OR → a | b;
  - ALU_MODE_CLEAR → all zeros.
  - Unlisted codes → no write.
- Output latency: one cycle after the pop edge.
  - tag_we_o = pop && rsp_we_i && mode writes.
  - tag_waddr_o and tag_wdata_o update only on a pop and hold otherwise.
  - tag_we_o is 0 in every cycle without a qualifying pop.
- rsp_we_i=0: the entry is still popped; no write.
- flush_i dominates:
  - count and pointers go to 0 next cycle;
  - a same-cycle push is dropped;
  - a same-cycle response produces no write and no error.

Optional Feature:
- Macro: LOAD_TAG_CHECK_EN.
- When defined:
  - adds input tcr_chk_i (1) and output load_tag_exc_o (1, reset 0);
  - on a pop, load_tag_exc_o=1 for one cycle (aligned with tag_we_o) if tcr_chk_i && (entry rs1_tag != 0);
  - the destination-tag write still occurs.
- When undefined: ports and logic are absent; behaviour is otherwise identical.

Test Plan:
- TAG_WIDTH=1, TPR mode=OR, en_a=en_b=1:
  - push rs1_tag=1, rd=5; next cycle rsp mem_tag=0, we=1 → one cycle later tag_we_o=1, waddr=5, wdata=1.
- Mode=AND, TAG_WIDTH=4:
  - push rs1_tag=4'b1100; rsp mem_tag=4'b1010 → wdata=4'b1000.
  - Same sequence with en_b=0 → wdata=4'b0000.
- TPR snapshot:
  - push with mode=CLEAR, then write TPR mode=OR before the response;
  - rsp mem_tag=1 → wdata=0, we=1.
  - Mode=OLD → tag_we_o stays 0.
- DEPTH=2 fill and wrap:
  - two pushes → req_ready_o=0, count_o=2; a third req_valid_i is not accepted;
  - simultaneous pop+push keeps count=2 only after space frees;
  - four loads in total → writes appear in issue order with rd 1,2,3,4.
- Boundaries:
  - rsp on empty → rsp_err_o pulses once, no write;
  - flush with two entries plus same-cycle rsp → count_o=0, no tag_we_o.
- Reset mid-operation: assert rst_n=0 with one entry queued → count_o=0 and outputs 0 immediately; a later rsp → rsp_err_o=1.
